spi_flash_seq: RTL and testbench

Command sequencer directly upstream of the SPI flash master. Turns word-level requests (read burst, word program, sector erase) into the master's single-transaction interface. Adds write-enable before destructive ops and status-register polling until the flash is no longer busy. Runs in 3-byte address mode; returns read data as a valid/ready stream.

---
 rtl/spi_flash_seq.sv | 259 +++++++++++++++++++++++++
 tb/tb_spi_flash_seq.sv | 598 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: command sequencer in front of the SPI flash master.
// Turns one word-level request (READ burst, PROGRAM word, ERASE sector) into
// a series of single transactions on the master's interface. Destructive ops
// are preceded by WREN and followed by status polling (RDSR) until WIP
// clears or POLL_MAX reads have been made. Addresses are 3-byte.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_*               request channel (valid/ready), latched at acceptance
//   rd_valid/rd_ready   read-word stream out, rd_data first flash bit in [31]
//   done, err           one-cycle end-of-request pulse; err marks poll timeout
//                       or reserved op
//   m_*                 single-transaction interface of the SPI flash master
//   dbg_state           current sequencer state, for observation only
//
// Handshakes: req_* and rd_* transfer on a clock edge where valid && ready
// are both high. A source that raises valid holds it and its payload stable
// until that edge. The master side instead uses validflag/tready: validflag
// is held until tready is sampled low (accepted), then dropped; completion
// is tready sampled high again.
module spi_flash_seq #(
  parameter int POLL_MAX = 1024,
  parameter int POLL_GAP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [7:0]  req_len,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [31:0] m_data_in,
  output logic [31:0] m_address,
  output logic [7:0]  m_command,
  output logic [2:0]  m_commtype,
  output logic [6:0]  m_nmiso_bits,
  output logic        m_validflag,
  input  logic [31:0] m_data_out,
  input  logic        m_tready,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_RD_OUT, S_GAP, S_FIN
  } state_t;

  // Which master transaction the ISSUE/WAIT states are currently carrying.
  typedef enum logic [2:0] {
    P_READ, P_WREN, P_PROG, P_ERASE, P_RDSR
  } prim_t;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_PROG  = 2'd1;
  localparam logic [1:0] OP_ERASE = 2'd2;

  localparam int PCW = $clog2(POLL_MAX + 1);
  localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  state_t          state_q, state_d;
  prim_t           prim_q, prim_d;
  logic            is_prog_q, is_prog_d;
  logic [23:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [7:0]      len_q, len_d;
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d;
  logic [GCW-1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            err_flag_q, err_flag_d;

  // The master shifts the first received bit into bit 0, so the word is
  // mirrored to put the first flash bit on top. For the 8-bit status read
  // only m_data_out[7:0] is meaningful and WIP (status bit 0) lands on [7].
  logic [31:0] rev_word;
  logic        wip;

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      rev_word[i] = m_data_out[31-i];
    end
    wip = m_data_out[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      prim_q     <= P_READ;
      is_prog_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      len_q      <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rd_data_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prim_q     <= prim_d;
      is_prog_q  <= is_prog_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      len_q      <= len_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rd_data_q  <= rd_data_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prim_d     = prim_q;
    is_prog_d  = is_prog_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_d      = len_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rd_data_d  = rd_data_q;
    err_flag_d = err_flag_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          len_d      = req_len;
          is_prog_d  = (req_op == OP_PROG);
          err_flag_d = 1'b0;
          case (req_op)
            OP_READ: begin
              prim_d  = P_READ;
              state_d = (req_len == 8'd0) ? S_FIN : S_ISSUE;
            end
            OP_PROG, OP_ERASE: begin
              prim_d  = P_WREN;
              state_d = S_ISSUE;
            end
            default: begin
              err_flag_d = 1'b1;
              state_d    = S_FIN;
            end
          endcase
        end
      end

      // validflag is up for exactly this cycle plus WAIT_ACC.
      S_ISSUE: state_d = S_WAIT_ACC;

      S_WAIT_ACC: begin
        if (!m_tready) state_d = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        if (m_tready) begin
          case (prim_q)
            P_READ: begin
              rd_data_d = rev_word;
              state_d   = S_RD_OUT;
            end
            P_WREN: begin
              prim_d  = is_prog_q ? P_PROG : P_ERASE;
              state_d = S_ISSUE;
            end
            P_PROG, P_ERASE: begin
              prim_d     = P_RDSR;
              poll_cnt_d = '0;
              state_d    = S_ISSUE;
            end
            default: begin
              poll_cnt_d = poll_cnt_q + PCW'(1);
              if (!wip) begin
                state_d = S_FIN;
              end else if (poll_cnt_d >= PCW'(POLL_MAX)) begin
                err_flag_d = 1'b1;
                state_d    = S_FIN;
              end else begin
                gap_cnt_d = '0;
                state_d   = S_GAP;
              end
            end
          endcase
        end
      end

      // The next word is fetched only after the consumer takes this one.
      S_RD_OUT: begin
        if (rd_ready) begin
          addr_d  = addr_q + 24'd4;
          len_d   = len_q - 8'd1;
          state_d = (len_q == 8'd1) ? S_FIN : S_ISSUE;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GCW'(POLL_GAP - 1)) state_d = S_ISSUE;
        else gap_cnt_d = gap_cnt_q + GCW'(1);
      end

      S_FIN: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // Master fields are decoded from the current primitive and are only
  // non-zero while a transaction is in flight, so they read 0 when idle.
  always_comb begin
    m_command    = '0;
    m_commtype   = '0;
    m_address    = '0;
    m_data_in    = '0;
    m_nmiso_bits = '0;
    if (state_q inside {S_ISSUE, S_WAIT_ACC, S_WAIT_DONE}) begin
      case (prim_q)
        P_READ: begin
          m_command    = 8'h03;
          m_commtype   = 3'b010;
          m_address    = {8'h00, addr_q};
          m_nmiso_bits = 7'd32;
        end
        P_WREN: begin
          m_command  = 8'h06;
          m_commtype = 3'b000;
        end
        P_PROG: begin
          m_command  = 8'h02;
          m_commtype = 3'b100;
          m_address  = {8'h00, addr_q};
          m_data_in  = wdata_q;
        end
        P_ERASE: begin
          m_command  = 8'h20;
          m_commtype = 3'b101;
          m_address  = {8'h00, addr_q};
        end
        default: begin
          m_command    = 8'h05;
          m_commtype   = 3'b001;
          m_nmiso_bits = 7'd8;
        end
      endcase
    end
  end

  assign m_validflag = (state_q == S_ISSUE) || (state_q == S_WAIT_ACC);
  assign req_ready   = (state_q == S_IDLE);
  assign rd_valid    = (state_q == S_RD_OUT);
  assign rd_data     = rd_data_q;
  assign done        = (state_q == S_FIN);
  assign err         = (state_q == S_FIN) && err_flag_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Self-checking bench for spi_flash_seq. A behavioural flash master answers
// transactions (bit-mirrored read words, scripted status bytes) and logs what
// it was asked to do; each test task pushes its expectations into queues and
// compares them with what the DUT and master log produced.
module tb_spi_flash_seq;

  localparam int POLL_MAX = 4;
  localparam int POLL_GAP = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_len;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        done;
  logic        err;
  logic [31:0] m_data_in;
  logic [31:0] m_address;
  logic [7:0]  m_command;
  logic [2:0]  m_commtype;
  logic [6:0]  m_nmiso_bits;
  logic        m_validflag;
  logic [31:0] m_data_out = '0;
  logic        m_tready = 1'b1;
  logic [2:0]  dbg_state;

  spi_flash_seq #(.POLL_MAX(POLL_MAX), .POLL_GAP(POLL_GAP)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .m_data_in(m_data_in), .m_address(m_address), .m_command(m_command),
    .m_commtype(m_commtype), .m_nmiso_bits(m_nmiso_bits),
    .m_validflag(m_validflag), .m_data_out(m_data_out), .m_tready(m_tready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  // txn layout: cmd[81:74] type[73:71] addr[70:39] data_in[38:7] nmiso[6:0]
  typedef logic [81:0] txn_t;

  txn_t        act_q[$];
  int          act_cyc_q[$];
  txn_t        exp_txn_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic [31:0] rd_resp_q[$];
  logic [7:0]  sr_q[$];
  logic [7:0]  sr_stuck = 8'h00;
  int          hs_cyc_q[$];

  function automatic logic [31:0] rev32(input logic [31:0] w);
    for (int i = 0; i < 32; i++) rev32[i] = w[31-i];
  endfunction

  function automatic logic [7:0] rev8(input logic [7:0] w);
    for (int i = 0; i < 8; i++) rev8[i] = w[7-i];
  endfunction

  function automatic txn_t f_read(input logic [23:0] a);
    return {8'h03, 3'b010, 8'h00, a, 32'h0, 7'd32};
  endfunction
  function automatic txn_t f_wren();
    return {8'h06, 3'b000, 32'h0, 32'h0, 7'd0};
  endfunction
  function automatic txn_t f_prog(input logic [23:0] a, input logic [31:0] d);
    return {8'h02, 3'b100, 8'h00, a, d, 7'd0};
  endfunction
  function automatic txn_t f_erase(input logic [23:0] a);
    return {8'h20, 3'b101, 8'h00, a, 32'h0, 7'd0};
  endfunction
  function automatic txn_t f_rdsr();
    return {8'h05, 3'b001, 32'h0, 32'h0, 7'd8};
  endfunction

  // Fields the master actually consumes for a given command.
  function automatic txn_t txn_mask(input logic [7:0] cmd);
    txn_t m;
    m = {8'hFF, 3'h7, 32'h0, 32'h0, 7'h0};
    if (cmd == 8'h03 || cmd == 8'h02 || cmd == 8'h20) m[70:39] = '1;
    if (cmd == 8'h02) m[38:7] = '1;
    if (cmd == 8'h03 || cmd == 8'h05) m[6:0] = '1;
    return m;
  endfunction

  // ---------------- flash master model ----------------
  int          busy = 0;
  logic [31:0] resp;
  logic [31:0] rnd;
  logic [7:0]  st;

  always @(negedge clk) begin
    if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        m_data_out = resp;
        m_tready   = 1'b1;
      end
    end else if (m_tready && m_validflag) begin
      act_q.push_back({m_command, m_commtype, m_address, m_data_in, m_nmiso_bits});
      act_cyc_q.push_back(cyc);
      m_tready = 1'b0;
      busy     = $urandom_range(3, 8);
      rnd      = $urandom();
      if (m_command == 8'h03) begin
        resp = (rd_resp_q.size() > 0) ? rev32(rd_resp_q.pop_front()) : rnd;
      end else if (m_command == 8'h05) begin
        st   = (sr_q.size() > 0) ? sr_q.pop_front() : sr_stuck;
        resp = {rnd[31:8], rev8(st)};
      end else begin
        resp = rnd;
      end
    end
  end

  // ---------------- output monitor ----------------
  int done_cnt  = 0;
  int stray_err = 0;
  int vf_cnt    = 0;

  always @(negedge clk) begin
    if (done) done_cnt++;
    else if (err) stray_err++;
    if (m_validflag) vf_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_req(input logic [1:0] op, input logic [23:0] a,
                          input logic [31:0] wd, input logic [7:0] len);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!req_ready) begin
      fails++;
      $display("FAIL req_ready_wait: req_ready=%b expected 1", req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = wd;
    req_len   = len;
    @(negedge clk);
    // Scramble the request lines to show the DUT works from its latched copy.
    req_valid = 1'b0;
    req_op    = 2'($urandom());
    req_addr  = 24'($urandom());
    req_wdata = $urandom();
    req_len   = 8'($urandom());
  endtask

  task automatic wait_done(input int budget, output logic got, output logic got_err);
    got = 1'b0;
    got_err = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (done) begin
        got = 1'b1;
        got_err = err;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  // Runs one READ request, collecting every word into obs_q. The first word
  // is held for 'hold' cycles with rd_ready low; any change or master
  // activity during that hold is counted in hold_bad.
  task automatic do_read(input logic [23:0] a, input logic [7:0] len, input int hold,
                         output int tmo, output int hold_bad,
                         output logic got, output logic got_err);
    int n;
    tmo = 0;
    hold_bad = 0;
    send_req(2'd0, a, $urandom(), len);
    for (int w = 0; w < int'(len); w++) begin
      n = 0;
      while (!rd_valid && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!rd_valid) begin
        tmo++;
        break;
      end
      obs_q.push_back(rd_data);
      if (w == 0) begin
        for (int h = 0; h < hold; h++) begin
          @(negedge clk);
          if (!rd_valid || rd_data !== obs_q[$] || m_validflag) hold_bad++;
        end
      end
      rd_ready = 1'b1;
      @(negedge clk);
      rd_ready = 1'b0;
      hs_cyc_q.push_back(cyc);
    end
    wait_done(200, got, got_err);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({req_ready, rd_valid, done, err, m_validflag} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_ctrl: ready/rd_valid/done/err/vf=%b expected 10000",
               {req_ready, rd_valid, done, err, m_validflag});
    end
    tests++;
    if ({rd_data, m_data_in, m_address, m_command, m_commtype, m_nmiso_bits} !== '0) begin
      fails++;
      $display("FAIL reset_data: rd_data=%h din=%h addr=%h cmd=%h type=%b nmiso=%0d expected all 0",
               rd_data, m_data_in, m_address, m_command, m_commtype, m_nmiso_bits);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || vf_cnt != 0) begin
      fails++;
      $display("FAIL reset_release: req_ready=%b vf_cycles=%0d expected 1/0", req_ready, vf_cnt);
    end
  endtask

  task automatic test_read_basic();
    int tmo, hb, d0;
    logic got, got_err;
    txn_t e, a;
    logic [31:0] ew, ow;
    d0 = done_cnt;
    rd_resp_q.push_back(32'h12345678); exp_q.push_back(32'h12345678);
    rd_resp_q.push_back(32'h9ABCDEF0); exp_q.push_back(32'h9ABCDEF0);
    exp_txn_q.push_back(f_read(24'h000100));
    exp_txn_q.push_back(f_read(24'h000104));
    do_read(24'h000100, 8'd2, 0, tmo, hb, got, got_err);
    tests++;
    if (!got || got_err !== 1'b0 || tmo != 0) begin
      fails++;
      $display("FAIL read_basic_done: done=%b err=%b timeouts=%0d expected 1/0/0", got, got_err, tmo);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL read_basic_done_count: %0d pulses expected 1", done_cnt - d0);
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      ow = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      tests++;
      if (ow !== ew) begin
        fails++;
        $display("FAIL read_basic_data: got %h expected %h", ow, ew);
      end
    end
    while (exp_txn_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if ((a & txn_mask(e[81:74])) !== (e & txn_mask(e[81:74]))) begin
        fails++;
        $display("FAIL read_basic_txn: got %h expected %h", a, e);
      end
    end
    act_cyc_q.delete();
    hs_cyc_q.delete();
  endtask

  task automatic test_program();
    int d0;
    logic got, got_err, gap_ok;
    txn_t e, a;
    d0 = done_cnt;
    sr_q.push_back(8'h03); sr_q.push_back(8'h03); sr_q.push_back(8'h03);
    sr_q.push_back(8'h02);
    exp_txn_q.push_back(f_wren());
    exp_txn_q.push_back(f_prog(24'h000040, 32'hCAFEF00D));
    repeat (4) exp_txn_q.push_back(f_rdsr());
    send_req(2'd1, 24'h000040, 32'hCAFEF00D, 8'($urandom()));
    wait_done(1000, got, got_err);
    tests++;
    if (!got || got_err !== 1'b0) begin
      fails++;
      $display("FAIL program_done: done=%b err=%b expected 1/0", got, got_err);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || stray_err != 0) begin
      fails++;
      $display("FAIL program_pulses: done=%0d stray_err=%0d expected 1/0", done_cnt - d0, stray_err);
    end
    gap_ok = 1'b1;
    for (int i = 3; i < act_cyc_q.size(); i++)
      if (act_cyc_q[i] - act_cyc_q[i-1] <= POLL_GAP) gap_ok = 1'b0;
    tests++;
    if (act_cyc_q.size() != 6 || !gap_ok) begin
      fails++;
      $display("FAIL program_poll_gap: txns=%0d gaps_ok=%b expected 6/1", act_cyc_q.size(), gap_ok);
    end
    while (exp_txn_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if ((a & txn_mask(e[81:74])) !== (e & txn_mask(e[81:74]))) begin
        fails++;
        $display("FAIL program_txn: got %h expected %h", a, e);
      end
    end
    tests++;
    if (act_q.size() != 0) begin
      fails++;
      $display("FAIL program_extra_txn: %0d extra expected 0", act_q.size());
    end
    act_q.delete();
    act_cyc_q.delete();
  endtask

  task automatic test_erase_timeout();
    int d0;
    logic got, got_err;
    txn_t e, a;
    d0 = done_cnt;
    sr_stuck = 8'h03;
    exp_txn_q.push_back(f_wren());
    exp_txn_q.push_back(f_erase(24'h012000));
    repeat (POLL_MAX) exp_txn_q.push_back(f_rdsr());
    send_req(2'd2, 24'h012000, $urandom(), 8'($urandom()));
    wait_done(1000, got, got_err);
    tests++;
    if (!got || got_err !== 1'b1) begin
      fails++;
      $display("FAIL erase_timeout_done: done=%b err=%b expected 1/1", got, got_err);
    end
    repeat (2) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1 || stray_err != 0) begin
      fails++;
      $display("FAIL erase_pulses: done=%0d stray_err=%0d expected 1/0", done_cnt - d0, stray_err);
    end
    tests++;
    if (act_q.size() != POLL_MAX + 2) begin
      fails++;
      $display("FAIL erase_txn_count: got %0d expected %0d", act_q.size(), POLL_MAX + 2);
    end
    while (exp_txn_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if ((a & txn_mask(e[81:74])) !== (e & txn_mask(e[81:74]))) begin
        fails++;
        $display("FAIL erase_txn: got %h expected %h", a, e);
      end
    end
    sr_stuck = 8'h00;
    act_q.delete();
    act_cyc_q.delete();
  endtask

  task automatic test_read_wrap();
    int tmo, hb;
    logic got, got_err;
    txn_t e, a;
    logic [31:0] ew, ow;
    rd_resp_q.push_back(32'hA5A50F0F); exp_q.push_back(32'hA5A50F0F);
    rd_resp_q.push_back(32'h3C3CC3C3); exp_q.push_back(32'h3C3CC3C3);
    exp_txn_q.push_back(f_read(24'hFFFFFC));
    exp_txn_q.push_back(f_read(24'h000000));
    do_read(24'hFFFFFC, 8'd2, 20, tmo, hb, got, got_err);
    tests++;
    if (!got || got_err !== 1'b0 || tmo != 0 || hb != 0) begin
      fails++;
      $display("FAIL read_wrap_hold: done=%b err=%b timeouts=%0d hold_bad=%0d expected 1/0/0/0",
               got, got_err, tmo, hb);
    end
    tests++;
    if (act_cyc_q.size() < 2 || hs_cyc_q.size() < 1 || act_cyc_q[1] < hs_cyc_q[0]) begin
      fails++;
      $display("FAIL read_wrap_order: second issue before first handshake (txns=%0d)", act_cyc_q.size());
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      ow = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      tests++;
      if (ow !== ew) begin
        fails++;
        $display("FAIL read_wrap_data: got %h expected %h", ow, ew);
      end
    end
    while (exp_txn_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if ((a & txn_mask(e[81:74])) !== (e & txn_mask(e[81:74]))) begin
        fails++;
        $display("FAIL read_wrap_txn: got %h expected %h", a, e);
      end
    end
    act_cyc_q.delete();
    hs_cyc_q.delete();
  endtask

  task automatic test_no_txn();
    int vf0;
    vf0 = vf_cnt;
    send_req(2'd0, 24'h000500, $urandom(), 8'd0);
    tests++;
    if (done !== 1'b1 || err !== 1'b0) begin
      fails++;
      $display("FAIL len0_done: done=%b err=%b expected 1/0", done, err);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL len0_pulse: done=%b req_ready=%b expected 0/1", done, req_ready);
    end
    send_req(2'd3, 24'h000600, $urandom(), 8'd5);
    tests++;
    if (done !== 1'b1 || err !== 1'b1) begin
      fails++;
      $display("FAIL reserved_done: done=%b err=%b expected 1/1", done, err);
    end
    repeat (4) @(negedge clk);
    tests++;
    if (vf_cnt != vf0 || act_q.size() != 0 || stray_err != 0) begin
      fails++;
      $display("FAIL no_txn_activity: vf_cycles=%0d txns=%0d stray_err=%0d expected 0/0/0",
               vf_cnt - vf0, act_q.size(), stray_err);
    end
  endtask

  task automatic test_back_to_back();
    int tmo, hb;
    logic got, got_err;
    logic [23:0] a0, wa;
    logic [7:0] len;
    logic [31:0] w, ew, ow;
    txn_t e, a;
    for (int r = 0; r < 3; r++) begin
      a0  = 24'($urandom_range(0, 32'h3FFFFF) << 2);
      len = 8'($urandom_range(1, 3));
      wa  = a0;
      for (int k = 0; k < int'(len); k++) begin
        w = $urandom();
        rd_resp_q.push_back(w);
        exp_q.push_back(w);
        exp_txn_q.push_back(f_read(wa));
        wa = wa + 24'd4;
      end
      do_read(a0, len, 0, tmo, hb, got, got_err);
      tests++;
      if (!got || got_err !== 1'b0 || tmo != 0) begin
        fails++;
        $display("FAIL b2b_done[%0d]: done=%b err=%b timeouts=%0d expected 1/0/0", r, got, got_err, tmo);
      end
    end
    while (exp_q.size() > 0) begin
      ew = exp_q.pop_front();
      ow = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
      tests++;
      if (ow !== ew) begin
        fails++;
        $display("FAIL b2b_data: got %h expected %h", ow, ew);
      end
    end
    while (exp_txn_q.size() > 0) begin
      e = exp_txn_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 'x;
      tests++;
      if ((a & txn_mask(e[81:74])) !== (e & txn_mask(e[81:74]))) begin
        fails++;
        $display("FAIL b2b_txn: got %h expected %h", a, e);
      end
    end
    act_cyc_q.delete();
    hs_cyc_q.delete();
  endtask

  task automatic test_reset_mid();
    int n;
    int tmo, hb;
    logic got, got_err;
    logic [31:0] ow;
    send_req(2'd1, 24'h000080, 32'h0BADF00D, 8'd0);
    n = 0;
    #1;
    while (!(act_q.size() >= 2 && !m_validflag && !m_tready) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    tests++;
    if (act_q.size() < 2 || (act_q[0] & txn_mask(8'h06)) !== (f_wren() & txn_mask(8'h06)) ||
        (act_q[1] & txn_mask(8'h02)) !== (f_prog(24'h000080, 32'h0BADF00D) & txn_mask(8'h02))) begin
      fails++;
      $display("FAIL reset_mid_prefix: txns=%0d expected WREN then PROG", act_q.size());
    end
    rst = 1'b1;
    #2;
    tests++;
    if ({req_ready, rd_valid, done, err, m_validflag} !== 5'b10000 || m_command !== 8'h00) begin
      fails++;
      $display("FAIL reset_mid_async: ready/rd_valid/done/err/vf=%b cmd=%h expected 10000/00",
               {req_ready, rd_valid, done, err, m_validflag}, m_command);
    end
    @(negedge clk);
    tests++;
    if ({m_data_in, m_address, m_commtype, m_nmiso_bits, m_validflag} !== '0) begin
      fails++;
      $display("FAIL reset_mid_fields: din=%h addr=%h type=%b nmiso=%0d vf=%b expected 0",
               m_data_in, m_address, m_commtype, m_nmiso_bits, m_validflag);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_ready: req_ready=%b expected 1", req_ready);
    end
    n = 0;
    while (!m_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!m_tready || act_q.size() != 2) begin
      fails++;
      $display("FAIL reset_mid_quiet: tready=%b txns=%0d expected 1/2", m_tready, act_q.size());
    end
    act_q.delete();
    act_cyc_q.delete();
    rd_resp_q.push_back(32'h5EED1234);
    exp_q.push_back(32'h5EED1234);
    do_read(24'h000200, 8'd1, 0, tmo, hb, got, got_err);
    ow = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hxxxxxxxx;
    tests++;
    if (!got || got_err !== 1'b0 || ow !== exp_q.pop_front()) begin
      fails++;
      $display("FAIL reset_mid_read: done=%b err=%b data=%h expected 1/0/5eed1234", got, got_err, ow);
    end
    tests++;
    if (act_q.size() != 1 || (act_q[0] & txn_mask(8'h03)) !== (f_read(24'h000200) & txn_mask(8'h03))) begin
      fails++;
      $display("FAIL reset_mid_read_txn: txns=%0d expected single READ at 000200", act_q.size());
    end
    act_q.delete();
    act_cyc_q.delete();
    hs_cyc_q.delete();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    rd_ready  = 1'b0;
    test_reset();
    test_read_basic();
    test_program();
    test_erase_timeout();
    test_read_wrap();
    test_no_txn();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
